// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module   : score_keeper
// Purpose  : Game score bookkeeping for the snake game. Counts accepted
//            food "eat" events while a game is in progress, saturates at
//            MAX_SCORE, and optionally tracks the best final score.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   MAX_SCORE  saturation ceiling of score (1..255)
//   POINTS     amount added per accepted eat event (1..255)
// Ports
//   VGA_clk        in   sole clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   eat            in   level, high while head overlaps food
//   start          in   single-cycle new-game request
//   game_over      in   single-cycle death indication
//   score          out  [7:0] current score (registered)
//   high_score     out  [7:0] best final score since reset (registered)
//   playing        out  high while the FSM is in PLAY (registered)
//   score_changed  out  one-cycle pulse accompanying a new score value
//   new_high       out  one-cycle pulse accompanying a raised high_score
// Build option
//   SCORE_KEEPER_HIGH_SCORE_EN  when defined, the high_score register and
//   the new_high pulse exist; otherwise both outputs are tied to 0.
// ============================================================================
module score_keeper #(
    parameter int MAX_SCORE = 99,
    parameter int POINTS    = 1
) (
    input  logic       VGA_clk,
    input  logic       rst_n,
    input  logic       eat,
    input  logic       start,
    input  logic       game_over,
    output logic [7:0] score,
    output logic [7:0] high_score,
    output logic       playing,
    output logic       score_changed,
    output logic       new_high
);

    localparam logic [8:0] C_MAX_SCORE = 9'(MAX_SCORE);
    localparam logic [8:0] C_POINTS    = 9'(POINTS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] score_q, score_d;
    logic       eat_prev_q;
    logic       playing_q;
    logic       score_changed_q;

    logic       w_eat_rise;
    logic [8:0] w_sum;
    logic [7:0] w_sat;

    // eat_prev_q resets high so a level already present at reset release
    // is not mistaken for a fresh rising edge.
    assign w_eat_rise = eat & ~eat_prev_q;

    // Nine-bit sum: score + POINTS can exceed 255 before saturation.
    assign w_sum = {1'b0, score_q} + C_POINTS;
    assign w_sat = (w_sum > C_MAX_SCORE) ? C_MAX_SCORE[7:0] : w_sum[7:0];

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PLAY;
                    score_d = 8'd0;
                end
            end
            PLAY: begin
                // A same-cycle eat is counted before the move to OVER, and
                // game_over takes priority over a simultaneous start.
                if (w_eat_rise) begin
                    score_d = w_sat;
                end
                if (game_over) begin
                    state_d = OVER;
                end
            end
            OVER: begin
                if (start) begin
                    state_d = PLAY;
                    score_d = 8'd0;
                end
            end
            default: begin
                state_d = IDLE;
                score_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge VGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            score_q         <= 8'd0;
            eat_prev_q      <= 1'b1;
            playing_q       <= 1'b0;
            score_changed_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            score_q         <= score_d;
            eat_prev_q      <= eat;
            playing_q       <= (state_d == PLAY);
            // Only a real value change pulses: saturated eats and clearing
            // an already-zero score stay silent.
            score_changed_q <= (score_d != score_q);
        end
    end

    assign score         = score_q;
    assign playing       = playing_q;
    assign score_changed = score_changed_q;

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
    logic [7:0] high_q;
    logic       new_high_q;
    logic       w_high_load;

    // Final score includes any eat accepted on the PLAY->OVER edge;
    // a tie with the current best does not count as a new high.
    assign w_high_load = (state_q == PLAY) && game_over && (score_d > high_q);

    always_ff @(posedge VGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            high_q     <= 8'd0;
            new_high_q <= 1'b0;
        end else begin
            if (w_high_load) begin
                high_q <= score_d;
            end
            new_high_q <= w_high_load;
        end
    end

    assign high_score = high_q;
    assign new_high   = new_high_q;
`else
    assign high_score = 8'd0;
    assign new_high   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_keeper
// Purpose  : Directed self-checking bench for score_keeper. Instance A uses
//            default parameters; instance B uses POINTS=10 for saturation.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_score_keeper;

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A
    logic       a_rst_n, a_eat, a_start, a_go;
    logic [7:0] a_score, a_hs;
    logic       a_play, a_sc, a_nh;
    // Instance B
    logic       b_rst_n, b_eat, b_start, b_go;
    logic [7:0] b_score, b_hs;
    logic       b_play, b_sc, b_nh;

    int checks   = 0;
    int failures = 0;

    score_keeper #(.MAX_SCORE(99), .POINTS(1)) u_a (
        .VGA_clk(clk), .rst_n(a_rst_n), .eat(a_eat), .start(a_start),
        .game_over(a_go), .score(a_score), .high_score(a_hs),
        .playing(a_play), .score_changed(a_sc), .new_high(a_nh)
    );

    score_keeper #(.MAX_SCORE(99), .POINTS(10)) u_b (
        .VGA_clk(clk), .rst_n(b_rst_n), .eat(b_eat), .start(b_start),
        .game_over(b_go), .score(b_score), .high_score(b_hs),
        .playing(b_play), .score_changed(b_sc), .new_high(b_nh)
    );

    // Advance to 1ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Convenience: single-cycle eat pulse on A followed by one idle cycle.
    task automatic a_pulse();
        a_eat = 1'b1; tick();
        a_eat = 1'b0; tick();
    endtask

    task automatic test_reset();
        a_rst_n = 1'b0; a_eat = 1'b1; a_start = 1'b0; a_go = 1'b0;
        b_rst_n = 1'b0; b_eat = 1'b0; b_start = 1'b0; b_go = 1'b0;
        #12;
        checks++;
        if ({a_score, a_hs, a_play, a_sc, a_nh} !== 19'd0) begin
            failures++;
            $display("FAIL reset_outputs: score=%0d hs=%0d play=%0b sc=%0b nh=%0b, required all 0",
                     a_score, a_hs, a_play, a_sc, a_nh);
        end
        @(negedge clk);
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        tick();
        // eat still high from before reset release; start a game
        a_start = 1'b1; tick(); a_start = 1'b0;
        checks++;
        if (a_play !== 1'b1 || a_score !== 8'd0) begin
            failures++;
            $display("FAIL start_from_idle: play=%0b score=%0d, required play=1 score=0", a_play, a_score);
        end
        tick(); tick();
        checks++;
        if (a_score !== 8'd0) begin
            failures++;
            $display("FAIL eat_high_at_release: score=%0d, required 0", a_score);
        end
        a_eat = 1'b0; tick();
    endtask

    task automatic test_eat_pulses();
        int pulses = 0;
        for (int i = 1; i <= 3; i++) begin
            a_eat = 1'b1; tick();
            if (a_sc === 1'b1) pulses++;
            checks++;
            if (a_score !== 8'(i)) begin
                failures++;
                $display("FAIL eat_pulse_%0d: score=%0d, required %0d", i, a_score, i);
            end
            a_eat = 1'b0; tick();
            if (a_sc === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 3 || a_play !== 1'b1) begin
            failures++;
            $display("FAIL score_changed_count: pulses=%0d play=%0b, required 3 and 1", pulses, a_play);
        end
    endtask

    task automatic test_eat_held();
        // End game at 3 (first high), then restart
        a_go = 1'b1; tick(); a_go = 1'b0;
        checks++;
        if (a_play !== 1'b0 || a_hs !== (HS_EN ? 8'd3 : 8'd0) || a_nh !== HS_EN) begin
            failures++;
            $display("FAIL first_game_over: play=%0b hs=%0d nh=%0b, required 0 %0d %0b",
                     a_play, a_hs, a_nh, HS_EN ? 3 : 0, HS_EN);
        end
        a_start = 1'b1; tick(); a_start = 1'b0;
        checks++;
        if (a_score !== 8'd0 || a_sc !== 1'b1 || a_play !== 1'b1) begin
            failures++;
            $display("FAIL restart_clear: score=%0d sc=%0b play=%0b, required 0 1 1", a_score, a_sc, a_play);
        end
        a_eat = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (a_score !== 8'd1) begin
            failures++;
            $display("FAIL eat_held_10: score=%0d, required 1", a_score);
        end
        a_eat = 1'b0; tick();
    endtask

    task automatic test_same_cycle_end();
        for (int i = 0; i < 4; i++) a_pulse();
        checks++;
        if (a_score !== 8'd5) begin
            failures++;
            $display("FAIL reach_5: score=%0d, required 5", a_score);
        end
        a_eat = 1'b1; a_go = 1'b1; tick(); a_eat = 1'b0; a_go = 1'b0;
        checks++;
        if (a_score !== 8'd6 || a_play !== 1'b0 || a_hs !== (HS_EN ? 8'd6 : 8'd0) || a_nh !== HS_EN) begin
            failures++;
            $display("FAIL eat_and_over: score=%0d play=%0b hs=%0d nh=%0b, required 6 0 %0d %0b",
                     a_score, a_play, a_hs, a_nh, HS_EN ? 6 : 0, HS_EN);
        end
        tick();
        checks++;
        if (a_nh !== 1'b0) begin
            failures++;
            $display("FAIL new_high_width: nh=%0b, required 0", a_nh);
        end
        // OVER ignores eat and game_over
        a_eat = 1'b1; a_go = 1'b1; tick(); a_eat = 1'b0; a_go = 1'b0; tick();
        checks++;
        if (a_score !== 8'd6 || a_play !== 1'b0 || a_sc !== 1'b0) begin
            failures++;
            $display("FAIL over_hold: score=%0d play=%0b sc=%0b, required 6 0 0", a_score, a_play, a_sc);
        end
    endtask

    task automatic test_no_new_high();
        a_start = 1'b1; tick(); a_start = 1'b0;
        checks++;
        if (a_score !== 8'd0 || a_hs !== (HS_EN ? 8'd6 : 8'd0) || a_play !== 1'b1) begin
            failures++;
            $display("FAIL second_start: score=%0d hs=%0d play=%0b", a_score, a_hs, a_play);
        end
        for (int i = 0; i < 4; i++) a_pulse();
        // start and game_over together: game_over wins
        a_start = 1'b1; a_go = 1'b1; tick(); a_start = 1'b0; a_go = 1'b0;
        checks++;
        if (a_score !== 8'd4 || a_play !== 1'b0 || a_hs !== (HS_EN ? 8'd6 : 8'd0) || a_nh !== 1'b0) begin
            failures++;
            $display("FAIL lower_game_end: score=%0d play=%0b hs=%0d nh=%0b, required 4 0 %0d 0",
                     a_score, a_play, a_hs, a_nh, HS_EN ? 6 : 0);
        end
        a_start = 1'b1; tick(); a_start = 1'b0;
        checks++;
        if (a_score !== 8'd0 || a_hs !== (HS_EN ? 8'd6 : 8'd0) || a_play !== 1'b1) begin
            failures++;
            $display("FAIL third_start: score=%0d hs=%0d play=%0b", a_score, a_hs, a_play);
        end
    endtask

    task automatic test_reset_mid_game();
        for (int i = 0; i < 7; i++) a_pulse();
        checks++;
        if (a_score !== 8'd7) begin
            failures++;
            $display("FAIL reach_7: score=%0d, required 7", a_score);
        end
        a_rst_n = 1'b0;
        #1;
        checks++;
        if ({a_score, a_hs, a_play, a_sc, a_nh} !== 19'd0) begin
            failures++;
            $display("FAIL async_reset: score=%0d hs=%0d play=%0b sc=%0b nh=%0b, required all 0",
                     a_score, a_hs, a_play, a_sc, a_nh);
        end
        @(negedge clk);
        a_rst_n = 1'b1;
        tick();
        a_pulse();
        checks++;
        if (a_score !== 8'd0 || a_play !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: score=%0d play=%0b, required 0 0", a_score, a_play);
        end
    endtask

    task automatic test_saturation();
        int exp_score = 0;
        int prev      = 0;
        b_start = 1'b1; tick(); b_start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            prev      = exp_score;
            exp_score = (i * 10 > 99) ? 99 : i * 10;
            b_eat = 1'b1; tick(); b_eat = 1'b0;
            checks++;
            if (b_score !== 8'(exp_score) || b_sc !== (exp_score != prev)) begin
                failures++;
                $display("FAIL sat_eat_%0d: score=%0d sc=%0b, required %0d %0b",
                         i, b_score, b_sc, exp_score, exp_score != prev);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_eat_pulses();
        test_eat_held();
        test_same_cycle_end();
        test_no_new_high();
        test_reset_mid_game();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter MAX_SCORE, default 99, saturation ceiling of score (legal 1..255; 99 keeps the two-digit display valid).
REQ-002 SHALL have parameter POINTS, default 1, amount added per accepted eat event (legal 1..255).
REQ-003 SHALL have port VGA_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port eat  input  1  level from the collision logic, high while the head overlaps food.
REQ-006 SHALL have port start  input  1  single-cycle request to begin a new game.
REQ-007 SHALL have port game_over  input  1  single-cycle collision-death indication.
REQ-008 SHALL have port score  output  8  current game score, registered, fed to the score display stage.
REQ-009 SHALL have port high_score  output  8  best final score since reset, registered.
REQ-010 SHALL have port playing  output  1  high while the FSM is in PLAY.
REQ-011 SHALL have port score_changed  output  1  one-cycle pulse in the cycle after score takes a new value.
REQ-012 SHALL have port new_high  output  1  one-cycle pulse when high_score is raised.

Function
REQ-013 SHALL detect eat rising edges via a registered copy eat_d; eat_rise = eat AND NOT eat_d; a held level counts once.
REQ-014 SHALL implement FSM states IDLE, PLAY, OVER; IDLE is the reset state.
REQ-015 IDLE: start -> PLAY with score cleared to 0 on that same edge; eat and game_over ignored.
REQ-016 PLAY: eat_rise -> score <= min(score + POINTS, MAX_SCORE) on the next edge; latency one cycle.
REQ-017 Addition SHALL use a 9-bit intermediate so score + POINTS never wraps; score SHALL never exceed MAX_SCORE.
REQ-018 PLAY: game_over -> OVER; eat_rise in the same cycle SHALL be counted before the transition.
REQ-019 PLAY: start ignored; start and game_over together -> game_over wins.
REQ-020 On the PLAY->OVER edge, if final score (including any same-cycle eat) > high_score, high_score SHALL load it and new_high pulses one cycle later for exactly one cycle; equal score does not update.
REQ-021 OVER: score and high_score held; eat and game_over ignored; start -> PLAY clearing score to 0, high_score retained.
REQ-022 score_changed SHALL pulse only when the registered score value differs from its previous value (saturated eats and clear-from-0 produce no pulse).
REQ-023 playing SHALL be a registered decode of state == PLAY.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, score 0, high_score 0, playing 0, score_changed 0, new_high 0.
REQ-025 eat_d SHALL reset to 1 so eat high at reset release is not counted.
REQ-026 Reset mid-game SHALL discard the in-progress score without updating high_score.

Configuration
REQ-027 Macro SCORE_KEEPER_HIGH_SCORE_EN defined: high_score register and new_high behave per REQ-020.
REQ-028 Macro SCORE_KEEPER_HIGH_SCORE_EN undefined: no high_score register synthesized; high_score tied to 0, new_high tied to 0; all other behaviour unchanged.

Verification
REQ-029 Reset, start, 3 separate eat pulses -> score 1,2,3 each one cycle after edge; 3 score_changed pulses; playing 1.
REQ-030 Start, eat held high 10 cycles -> score increments once only to 1.
REQ-031 POINTS=10, MAX_SCORE=99, 12 eat pulses -> score 10..90 then 99, stays 99; no score_changed on 12th.
REQ-032 Score 5, eat_rise and game_over same cycle -> score 6, state OVER, high_score 6, one new_high pulse.
REQ-033 Second game ends at 4 with high_score 6 -> high_score stays 6, no new_high; start -> score 0, high_score 6.
REQ-034 rst_n low mid-PLAY at score 7 -> all outputs 0 asynchronously, state IDLE; macro undefined build -> high_score/new_high constantly 0.
